// File: rtl/fleet_controller_pkg.sv
// fleet_controller_pkg: shared state enum and default geometry for the alien fleet
// Holds the controller state type, the default fleet geometry and the alive-mask width.
package fleet_controller_pkg;
  typedef enum logic [1:0] {RUN, CLEARED, LANDED} fleetState_t;
  localparam int N_COLS_D = 8;
  localparam int N_ROWS_D = 4;
  localparam int PITCH_X_D = 32;
  localparam int PITCH_Y_D = 24;
  localparam int X_START_D = 64;
  localparam int Y_START_D = 32;
  localparam int STEP_X_D = 8;
  localparam int STEP_Y_D = 16;
  localparam int X_MAX_D = 640;
  localparam int Y_LIMIT_D = 400;
  localparam int MASK_W = N_COLS_D * N_ROWS_D;
endpackage

// File: rtl/fleet_span.sv
// fleet_span: extent of the living fleet, derived combinationally from the alive mask
// Ports: aliveMask (bit row*N_COLS+col) in; leftCol/rightCol = outermost occupied
// columns, bottomRow = lowest occupied row, empty = no alien alive.
module fleet_span #(
  parameter int N_COLS = 8,
  parameter int N_ROWS = 4,
  localparam int CW = N_COLS > 1 ? $clog2(N_COLS) : 1,
  localparam int RW = N_ROWS > 1 ? $clog2(N_ROWS) : 1
) (
  input  logic [N_ROWS*N_COLS-1:0] aliveMask,
  output logic [CW-1:0]            leftCol,
  output logic [CW-1:0]            rightCol,
  output logic [RW-1:0]            bottomRow,
  output logic                     empty
);
  logic [N_COLS-1:0] colAny;
  logic [N_ROWS-1:0] rowAny;
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic [N_ROWS-1:0] bits;
    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      assign bits[r] = aliveMask[r*N_COLS+c];
    end
    assign colAny[c] = |bits;
  end
  for (genvar r = 0; r < N_ROWS; r++) begin : g_rowAny
    assign rowAny[r] = |aliveMask[r*N_COLS +: N_COLS];
  end
  assign empty = ~|aliveMask;
  // Scan directions are chosen so the last hit wins: lowest column for left,
  // highest column for right, highest row for bottom.
  always_comb begin
    leftCol = '0;
    rightCol = '0;
    bottomRow = '0;
    for (int i = N_COLS - 1; i >= 0; i--) if (colAny[i]) leftCol = CW'(i);
    for (int i = 0; i < N_COLS; i++) if (colAny[i]) rightCol = CW'(i);
    for (int i = 0; i < N_ROWS; i++) if (rowAny[i]) bottomRow = RW'(i);
  end
endmodule

// File: rtl/fleet_controller.sv
// fleet_controller: zig-zag movement, hit bookkeeping and end-of-wave status of the alien fleet
// Ports: clk, reset (sync, active-high); stepTick/frameStart movement pulses; killValid/
// killRow/killCol hit report; restart new wave. Registered outputs: xFleet/yFleet origin,
// aliveMask, dirRight, fleetCleared, fleetLanded, killCount (saturating, kept over restart).
module fleet_controller
  import fleet_controller_pkg::*;
#(
  parameter int N_COLS = N_COLS_D,
  parameter int N_ROWS = N_ROWS_D,
  parameter int PITCH_X = PITCH_X_D,
  parameter int PITCH_Y = PITCH_Y_D,
  parameter int X_START = X_START_D,
  parameter int Y_START = Y_START_D,
  parameter int STEP_X = STEP_X_D,
  parameter int STEP_Y = STEP_Y_D,
  parameter int X_MAX = X_MAX_D,
  parameter int Y_LIMIT = Y_LIMIT_D
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stepTick,
  input  logic                     frameStart,
  input  logic                     killValid,
  input  logic [1:0]               killRow,
  input  logic [2:0]               killCol,
  input  logic                     restart,
  output logic [9:0]               xFleet,
  output logic [9:0]               yFleet,
  output logic [N_ROWS*N_COLS-1:0] aliveMask,
  output logic                     dirRight,
  output logic                     fleetCleared,
  output logic                     fleetLanded,
  output logic [5:0]               killCount
);
  localparam int W = N_ROWS * N_COLS;
  localparam int CW = N_COLS > 1 ? $clog2(N_COLS) : 1;
  localparam int RW = N_ROWS > 1 ? $clog2(N_ROWS) : 1;
  fleetState_t state, stateNext;
  logic [9:0] xNext, yNext, yDesc;
  logic [W-1:0] maskNext, killBit;
  logic [5:0] countNext;
  logic dirNext, pending, pendingNext, doStep, doStepNext, clearedNext, landedNext;
  logic [CW-1:0] leftCol, rightCol;
  logic [RW-1:0] bottomRow;
  logic empty, inRange, killHit, edgeHit, landHit;
  logic [15:0] rightEdge, leftEdge, landEdge;

  fleet_span #(.N_COLS(N_COLS), .N_ROWS(N_ROWS)) span (
    .aliveMask(aliveMask),
    .leftCol(leftCol),
    .rightCol(rightCol),
    .bottomRow(bottomRow),
    .empty(empty)
  );

  // Span comes from the registered mask, so a same-cycle kill never alters this step.
  assign rightEdge = 16'(xFleet) + (16'(rightCol) + 16'd1) * 16'(PITCH_X) + 16'(STEP_X);
  assign leftEdge = 16'(xFleet) + 16'(leftCol) * 16'(PITCH_X);
  assign edgeHit = dirRight ? rightEdge > 16'(X_MAX) : leftEdge < 16'(STEP_X);
  assign yDesc = yFleet + 10'(STEP_Y);
  assign landEdge = 16'(yDesc) + (16'(bottomRow) + 16'd1) * 16'(PITCH_Y);
  assign landHit = landEdge >= 16'(Y_LIMIT);
  // Column check matters when N_COLS is not a power of two: it stops aliasing into the next row.
  assign inRange = int'(killRow) < N_ROWS && int'(killCol) < N_COLS;
  assign killBit = W'(1) << (int'(killRow) * N_COLS + int'(killCol));
  assign killHit = killValid && inRange && !empty && |(aliveMask & killBit);

  always_comb begin
    stateNext = state;
    xNext = xFleet;
    yNext = yFleet;
    dirNext = dirRight;
    maskNext = aliveMask;
    countNext = killCount;
    pendingNext = pending;
    doStepNext = 1'b0;
    clearedNext = fleetCleared;
    landedNext = fleetLanded;
    if (restart) begin
      stateNext = RUN;
      xNext = 10'(X_START);
      yNext = 10'(Y_START);
      dirNext = 1'b1;
      maskNext = '1;
      pendingNext = 1'b0;
      clearedNext = 1'b0;
      landedNext = 1'b0;
    end else if (state == RUN) begin
      // Ticks collapse into one pending step; frameStart hands it to doStep for the next cycle.
      pendingNext = frameStart ? 1'b0 : pending | stepTick;
      doStepNext = frameStart & (pending | stepTick);
      if (doStep) begin
        xNext = edgeHit ? xFleet : dirRight ? xFleet + 10'(STEP_X) : xFleet - 10'(STEP_X);
        yNext = edgeHit ? yDesc : yFleet;
        dirNext = edgeHit ? !dirRight : dirRight;
        stateNext = edgeHit && landHit ? LANDED : state;
      end
      // Evaluated after the step so clearing the last alien overrides a simultaneous landing.
      if (killHit) begin
        maskNext = aliveMask & ~killBit;
        countNext = killCount == 6'd63 ? killCount : killCount + 6'd1;
        stateNext = maskNext == '0 ? CLEARED : stateNext;
      end
      clearedNext = stateNext == CLEARED;
      landedNext = stateNext == LANDED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      xFleet <= 10'(X_START);
      yFleet <= 10'(Y_START);
      dirRight <= 1'b1;
      aliveMask <= '1;
      killCount <= '0;
      pending <= 1'b0;
      doStep <= 1'b0;
      fleetCleared <= 1'b0;
      fleetLanded <= 1'b0;
    end else begin
      state <= stateNext;
      xFleet <= xNext;
      yFleet <= yNext;
      dirRight <= dirNext;
      aliveMask <= maskNext;
      killCount <= countNext;
      pending <= pendingNext;
      doStep <= doStepNext;
      fleetCleared <= clearedNext;
      fleetLanded <= landedNext;
    end
  end
endmodule

// File: tb/tb_fleet_controller.sv
// tb_fleet_controller: directed self-checking bench for fleet_controller
// Drives inputs on the falling edge and checks registered outputs on the following falling edge.
module tb_fleet_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stepTick = 1'b0;
  logic frameStart = 1'b0;
  logic killValid = 1'b0, killValid2 = 1'b0;
  logic [1:0] killRow = '0, killRow2 = '0;
  logic [2:0] killCol = '0, killCol2 = '0;
  logic restart = 1'b0, restart2 = 1'b0;
  logic [9:0] xFleet, yFleet, xFleet2, yFleet2;
  logic [31:0] aliveMask, aliveMask2;
  logic dirRight, fleetCleared, fleetLanded, dirRight2, fleetCleared2, fleetLanded2;
  logic [5:0] killCount, killCount2;
  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fleet_controller dut (
    .clk(clk), .reset(reset), .stepTick(stepTick), .frameStart(frameStart),
    .killValid(killValid), .killRow(killRow), .killCol(killCol), .restart(restart),
    .xFleet(xFleet), .yFleet(yFleet), .aliveMask(aliveMask), .dirRight(dirRight),
    .fleetCleared(fleetCleared), .fleetLanded(fleetLanded), .killCount(killCount)
  );

  fleet_controller #(.Y_LIMIT(160)) dut2 (
    .clk(clk), .reset(reset), .stepTick(stepTick), .frameStart(frameStart),
    .killValid(killValid2), .killRow(killRow2), .killCol(killCol2), .restart(restart2),
    .xFleet(xFleet2), .yFleet(yFleet2), .aliveMask(aliveMask2), .dirRight(dirRight2),
    .fleetCleared(fleetCleared2), .fleetLanded(fleetLanded2), .killCount(killCount2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic doStep();
    stepTick = 1'b1;
    frameStart = 1'b1;
    @(negedge clk);
    stepTick = 1'b0;
    frameStart = 1'b0;
    @(negedge clk);
  endtask

  task automatic kill1(input int r, input int c);
    killValid = 1'b1;
    killRow = 2'(r);
    killCol = 3'(c);
    @(negedge clk);
    killValid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    doReset();
    chk("rst_x", 32'(xFleet), 64);
    chk("rst_y", 32'(yFleet), 32);
    chk("rst_mask", aliveMask, 32'hFFFF_FFFF);
    chk("rst_dir", 32'(dirRight), 1);
    chk("rst_cnt", 32'(killCount), 0);
    chk("rst_clr", 32'(fleetCleared), 0);
    chk("rst_lnd", 32'(fleetLanded), 0);
    chk("rst2_y", 32'(yFleet2), 32);

    // tick without frameStart holds; step lands the cycle after frameStart
    stepTick = 1'b1;
    @(negedge clk);
    stepTick = 1'b0;
    repeat (2) @(negedge clk);
    chk("tick_noframe_x", 32'(xFleet), 64);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    chk("frame_edge_x", 32'(xFleet), 64);
    @(negedge clk);
    chk("step_x", 32'(xFleet), 72);

    // three ticks coalesce into one step
    doReset();
    for (int i = 0; i < 3; i++) begin
      stepTick = 1'b1;
      @(negedge clk);
      stepTick = 1'b0;
      @(negedge clk);
    end
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    repeat (4) @(negedge clk);
    chk("coalesce_x", 32'(xFleet), 72);

    // long march: right edge descend, left edge descend, landing on dut2
    doReset();
    killValid2 = 1'b1;
    killRow2 = 2'd0;
    killCol2 = 3'd0;
    @(negedge clk);
    killValid2 = 1'b0;
    chk("k2_cnt", 32'(killCount2), 1);
    chk("k2_mask", aliveMask2, 32'hFFFF_FFFE);
    repeat (40) doStep();
    chk("s40_x", 32'(xFleet), 384);
    chk("s40_y", 32'(yFleet), 32);
    chk("s40_x2", 32'(xFleet2), 384);
    doStep();
    chk("s41_x", 32'(xFleet), 384);
    chk("s41_y", 32'(yFleet), 48);
    chk("s41_dir", 32'(dirRight), 0);
    chk("s41_y2", 32'(yFleet2), 48);
    chk("s41_lnd2", 32'(fleetLanded2), 0);
    repeat (48) doStep();
    chk("s89_x", 32'(xFleet), 0);
    chk("s89_x2", 32'(xFleet2), 0);
    doStep();
    chk("s90_y", 32'(yFleet), 64);
    chk("s90_dir", 32'(dirRight), 1);
    chk("s90_lnd", 32'(fleetLanded), 0);
    chk("s90_y2", 32'(yFleet2), 64);
    chk("s90_lnd2", 32'(fleetLanded2), 1);
    chk("s90_x2", 32'(xFleet2), 0);
    doStep();
    chk("s91_x", 32'(xFleet), 8);
    chk("landed_hold_x2", 32'(xFleet2), 0);
    chk("landed_hold_y2", 32'(yFleet2), 64);
    killValid2 = 1'b1;
    killRow2 = 2'd1;
    killCol2 = 3'd1;
    @(negedge clk);
    killValid2 = 1'b0;
    chk("landed_nokill_cnt2", 32'(killCount2), 1);
    restart2 = 1'b1;
    @(negedge clk);
    restart2 = 1'b0;
    chk("rs_x2", 32'(xFleet2), 64);
    chk("rs_y2", 32'(yFleet2), 32);
    chk("rs_lnd2", 32'(fleetLanded2), 0);
    chk("rs_dir2", 32'(dirRight2), 1);
    chk("rs_mask2", aliveMask2, 32'hFFFF_FFFF);
    chk("rs_cnt2", 32'(killCount2), 1);
    doStep();
    chk("rs_step_x2", 32'(xFleet2), 72);

    // single kill and repeat
    doReset();
    kill1(2, 3);
    chk("kill_mask", aliveMask, 32'hFFF7_FFFF);
    chk("kill_cnt", 32'(killCount), 1);
    kill1(2, 3);
    chk("rekill_mask", aliveMask, 32'hFFF7_FFFF);
    chk("rekill_cnt", 32'(killCount), 1);

    // clear the whole fleet
    for (int i = 0; i < 32; i++) begin
      if (i != 19) begin
        kill1(i / 8, i % 8);
        chk($sformatf("clr_%0d", i), 32'(fleetCleared), (i == 31) ? 1 : 0);
      end
    end
    chk("clr_cnt", 32'(killCount), 32);
    chk("clr_mask", aliveMask, 0);
    doStep();
    chk("clr_hold_x", 32'(xFleet), 64);
    chk("clr_still", 32'(fleetCleared), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/fleet_controller.md
FLEET_CONTROLLER -- requirements
Module: fleet_controller

Interface
REQ-001 SHALL have parameter N_COLS, default 8, meaning alien columns.
REQ-002 SHALL have parameter N_ROWS, default 4, meaning alien rows.
REQ-003 SHALL have parameters PITCH_X 32 and PITCH_Y 24, meaning alien cell pitch in pixels.
REQ-004 SHALL have parameters X_START 64 and Y_START 32, meaning initial fleet origin.
REQ-005 SHALL have parameters STEP_X 8 and STEP_Y 16, meaning horizontal step and descent in pixels.
REQ-006 SHALL have parameters X_MAX 640 and Y_LIMIT 400, meaning right screen bound and landing line.
REQ-007 SHALL have port clk, input, 1, meaning the single system clock.
REQ-008 SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-009 SHALL have port stepTick, input, 1, meaning a one-cycle movement request pulse from the zig-zag time unit.
REQ-010 SHALL have port frameStart, input, 1, meaning a one-cycle pulse at vertical blanking start.
REQ-011 SHALL have ports killValid (1), killRow (2) and killCol (3), all inputs, meaning a hit report from the laser.
REQ-012 SHALL have port restart, input, 1, meaning a one-cycle new-wave request.
REQ-013 SHALL have ports xFleet and yFleet, output, 10 each, meaning the fleet origin in pixels.
REQ-014 SHALL have port aliveMask, output, N_ROWS*N_COLS, meaning alive bits, where bit index = row*N_COLS+col.
REQ-015 SHALL have port dirRight, output, 1, meaning horizontal direction (1 = right).
REQ-016 SHALL have ports fleetCleared and fleetLanded, output, 1 each, meaning terminal status.
REQ-017 SHALL have port killCount, output, 6, meaning saturating hit counter.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 The state machine SHALL have states RUN, CLEARED and LANDED; CLEARED and LANDED SHALL persist until restart or reset.
REQ-020 In RUN, stepTick SHALL set a pending flag; extra ticks before a frameStart SHALL NOT accumulate.
REQ-021 A pending step SHALL be applied on the cycle after frameStart, and pending SHALL then clear.
- stepTick and frameStart in the same cycle: the step applies on the next cycle.
REQ-022 Span logic SHALL derive leftCol, rightCol and bottomRow from aliveMask.
- These values are combinational.
- They use the registered (pre-kill) mask.
REQ-023 A rightward step SHALL do the following:
- If xFleet+(rightCol+1)*PITCH_X+STEP_X > X_MAX, descend.
- Otherwise, xFleet += STEP_X.
REQ-024 A leftward step SHALL do the following:
- If xFleet+leftCol*PITCH_X < STEP_X, descend.
- Otherwise, xFleet -= STEP_X.
REQ-025 Descend SHALL mean yFleet += STEP_Y, invert dirRight, and leave xFleet unchanged.
REQ-026 After a descend, if yFleet_new+(bottomRow+1)*PITCH_Y >= Y_LIMIT, the state SHALL go to LANDED and fleetLanded=1.
REQ-027 A kill SHALL be handled as follows:
- killValid with an in-range, alive target clears that bit on the next cycle.
- killCount then increments, saturating at 63.
- A dead or out-of-range target causes no change.
REQ-028 A kill and a step in the same cycle SHALL both take effect; the step uses the pre-kill span.
REQ-029 When aliveMask becomes all-zero, the state SHALL go to CLEARED on the same update and fleetCleared=1.
REQ-030 A kill landing simultaneously with LANDED SHALL be honoured; CLEARED SHALL take priority.
REQ-031 In CLEARED and LANDED, stepTick and killValid SHALL be ignored.
REQ-032 restart SHALL restore all reset values except killCount, which is retained.

Reset
REQ-033 Reset SHALL be synchronous and active-high, and SHALL take priority over restart and all other inputs.
REQ-034 The reset values SHALL be as follows:
- xFleet=X_START, yFleet=Y_START, aliveMask all ones.
- dirRight=1, state RUN, pending=0.
- killCount=0, fleetCleared=0, fleetLanded=0.

Structure
REQ-035 A shared package SHALL hold the following:
- the state enum (RUN/CLEARED/LANDED);
- the default geometry constants;
- the mask width.
REQ-036 Span logic SHALL be a sub-module named fleet_span.
- Input: aliveMask.
- Outputs: leftCol, rightCol, bottomRow and empty.

Verification
REQ-037 Reset, then a stepTick pulse with no frameStart -> xFleet stays 64; after frameStart -> xFleet=72 one cycle later.
REQ-038 Three stepTicks, then one frameStart -> a single step, xFleet=72.
REQ-039 41 applied steps from reset -> xFleet=384 after 40 steps; the 41st gives yFleet=48, dirRight=0, xFleet=384.
REQ-040 Kill row 2, col 3 -> aliveMask bit 19=0 and killCount=1; repeating the kill -> no change.
REQ-041 Kill all 32 aliens -> fleetCleared=1 on the last kill; later stepTick/frameStart leave xFleet unchanged.
REQ-042 With Y_LIMIT=160, two descends -> yFleet=64 and fleetLanded=1; restart -> RUN, x=64, y=32, killCount retained.
